// File: rtl/agc_gain_loop_if.sv
// Sample, level and power bus between agc_gain_loop and its neighbours.
// With AGC_FREEZE_EN defined the bus also carries the freeze input.
interface agc_gain_loop_if #(
  parameter int DWIDTH = 16,
  parameter int GWIDTH = 18,
  parameter int PWIDTH = 27,
  parameter int LWIDTH = 48
);
  logic                     in_valid;
  logic signed [DWIDTH-1:0] in_data;
  logic        [LWIDTH-1:0] level_in;
  logic                     out_valid;
  logic signed [DWIDTH-1:0] out_data;
  logic                     ema_valid;
  logic        [PWIDTH-1:0] ema_d;
  logic        [GWIDTH-1:0] gain;
  logic                     locked;
`ifdef AGC_FREEZE_EN
  logic                     freeze;

  modport master (
    output in_valid, in_data, level_in, freeze,
    input  out_valid, out_data, ema_valid, ema_d, gain, locked
  );
  modport slave (
    input  in_valid, in_data, level_in, freeze,
    output out_valid, out_data, ema_valid, ema_d, gain, locked
  );
`else
  modport master (
    output in_valid, in_data, level_in,
    input  out_valid, out_data, ema_valid, ema_d, gain, locked
  );
  modport slave (
    input  in_valid, in_data, level_in,
    output out_valid, out_data, ema_valid, ema_d, gain, locked
  );
`endif
endinterface

// File: rtl/agc_gain_loop.sv
// Closed-loop AGC gain stage: gains the sample stream, feeds output power to the EMA and
// steps the gain from the returned level. AGC_FREEZE_EN adds a freeze input holding gain/locked.
module agc_gain_loop #(
  parameter int                DWIDTH        = 16,
  parameter int                GWIDTH        = 18,
  parameter int                GFRAC         = 14,
  parameter int                PWIDTH        = 27,
  parameter int                LWIDTH        = 48,
  parameter logic [LWIDTH-1:0] TARGET        = LWIDTH'(64'd1073741824),
  parameter logic [LWIDTH-1:0] HYST          = LWIDTH'(64'd67108864),
  parameter int                UPDATE_PERIOD = 64,
  parameter int                EMA_LAT       = 4,
  parameter int                STEP_SHIFT    = 4,
  parameter logic [GWIDTH-1:0] GAIN_MIN      = GWIDTH'(32'd256),
  parameter logic [GWIDTH-1:0] GAIN_MAX      = GWIDTH'(32'd262143),
  parameter logic [GWIDTH-1:0] GAIN_INIT     = GWIDTH'(32'd16384)
) (
  input  logic          clk,
  input  logic          rst,
  agc_gain_loop_if.slave bus
);
  localparam int PRODW = DWIDTH + GWIDTH + 1;
  localparam int CW    = $clog2(UPDATE_PERIOD + 1);
  localparam int WW    = $clog2(EMA_LAT + 2);
  localparam logic signed [PRODW-1:0] RND    = {{(PRODW-1){1'b0}}, 1'b1} << (GFRAC - 1);
  localparam logic signed [PRODW-1:0] SAT_HI = {{(PRODW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [PRODW-1:0] SAT_LO = {{(PRODW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
  // One extra bit so the window edges cannot wrap
  localparam logic [LWIDTH:0] LEVEL_HI = {1'b0, TARGET} + {1'b0, HYST};
  localparam logic [LWIDTH:0] LEVEL_LO = {1'b0, TARGET} - {1'b0, HYST};

  typedef enum logic [1:0] {ST_COUNT = 2'd0, ST_WAIT = 2'd1, ST_ADJUST = 2'd2} state_t;

  state_t                     state, state_nx;
  logic        [CW-1:0]       cnt, cnt_nx, cnt_inc;
  logic        [WW-1:0]       wait_cnt, wait_nx;
  logic        [GWIDTH-1:0]   cur_gain, gain_nx;
  logic                       cur_locked, locked_nx;
  logic                       s1_valid, s2_valid, s3_valid;
  logic signed [DWIDTH-1:0]   s1_data, s2_data, sat_data;
  logic        [GWIDTH-1:0]   s1_gain;
  logic        [PWIDTH-1:0]   s3_power;
  logic signed [PRODW-1:0]    prod, rounded;
  logic signed [2*DWIDTH-1:0] sq;
  logic        [GWIDTH:0]     gain_ext, step, raise_sum, raised, lowered;
  logic        [LWIDTH:0]     level;
  logic                       frozen;

`ifdef AGC_FREEZE_EN
  assign frozen = bus.freeze;
`else
  assign frozen = 1'b0;
`endif

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.ema_valid = s3_valid;
  assign bus.ema_d     = s3_power;
  assign bus.gain      = cur_gain;
  assign bus.locked    = cur_locked;

  // Gain multiply, round half up, saturate to the sample range; square for the power word
  always_comb begin
    prod    = PRODW'(s1_data) * PRODW'($signed({1'b0, s1_gain}));
    rounded = (prod + RND) >>> GFRAC;
    if (rounded > SAT_HI) begin
      sat_data = SAT_HI[DWIDTH-1:0];
    end else if (rounded < SAT_LO) begin
      sat_data = SAT_LO[DWIDTH-1:0];
    end else begin
      sat_data = rounded[DWIDTH-1:0];
    end
    sq = (2*DWIDTH)'(s2_data) * (2*DWIDTH)'(s2_data);
  end

  // Sample pipeline: stage 1 latches sample and the gain in force, stage 2 gains, stage 3 squares
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_gain  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s3_valid <= 1'b0;
      s3_power <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_data  <= bus.in_data;
      s1_gain  <= cur_gain;
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= sat_data;
      s3_valid <= s2_valid;
      if (s2_valid) s3_power <= sq[2*DWIDTH-1 -: PWIDTH];
    end
  end

  // Candidate gains one step up and one step down, each clamped to its limit
  always_comb begin
    gain_ext = {1'b0, cur_gain};
    level    = {1'b0, bus.level_in};
    if ((cur_gain >> STEP_SHIFT) == '0) begin
      step = {{GWIDTH{1'b0}}, 1'b1};
    end else begin
      step = {1'b0, cur_gain >> STEP_SHIFT};
    end
    raise_sum = gain_ext + step;
    if (raise_sum > {1'b0, GAIN_MAX}) begin
      raised = {1'b0, GAIN_MAX};
    end else begin
      raised = raise_sum;
    end
    if (gain_ext < ({1'b0, GAIN_MIN} + step)) begin
      lowered = {1'b0, GAIN_MIN};
    end else begin
      lowered = gain_ext - step;
    end
  end

  // Update FSM: count outputs, let the EMA settle, then compare and step once
  always_comb begin
    state_nx  = state;
    wait_nx   = wait_cnt;
    gain_nx   = cur_gain;
    locked_nx = cur_locked;
    cnt_inc   = s2_valid ? cnt + CW'(1'b1) : cnt;
    cnt_nx    = cnt_inc;
    case (state)
      ST_COUNT: begin
        if (s2_valid && (cnt >= CW'(UPDATE_PERIOD - 1))) begin
          state_nx = ST_WAIT;
          cnt_nx   = '0;
          wait_nx  = WW'(EMA_LAT);
        end else begin
          state_nx = ST_COUNT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt <= WW'(1'b1)) begin
          state_nx = ST_ADJUST;
          wait_nx  = '0;
        end else begin
          wait_nx  = wait_cnt - WW'(1'b1);
        end
      end
      ST_ADJUST: begin
        state_nx = ST_COUNT;
        if (frozen) begin
          gain_nx   = cur_gain;
          locked_nx = cur_locked;
        end else if (level > LEVEL_HI) begin
          gain_nx   = lowered[GWIDTH-1:0];
          locked_nx = 1'b0;
        end else if (level < LEVEL_LO) begin
          gain_nx   = raised[GWIDTH-1:0];
          locked_nx = 1'b0;
        end else begin
          gain_nx   = cur_gain;
          locked_nx = 1'b1;
        end
      end
      default: begin
        state_nx = ST_COUNT;
        cnt_nx   = '0;
        wait_nx  = '0;
      end
    endcase
  end

  // FSM, counters and gain registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_COUNT;
      cnt        <= '0;
      wait_cnt   <= '0;
      cur_gain   <= GAIN_INIT;
      cur_locked <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      wait_cnt   <= wait_nx;
      cur_gain   <= gain_nx;
      cur_locked <= locked_nx;
    end
  end
endmodule

// File: tb/tb_agc_gain_loop.sv
// Scoreboard bench for agc_gain_loop: data/power predicted at drive time, gain from a loop model.
// Two extra instances with GAIN_INIT 8192 and 32768 exercise rounding and saturation.
module tb_agc_gain_loop;
  localparam longint HI   = 64'd1140850688;   // 2^30 + 2^26
  localparam longint LO   = 64'd1006632960;   // 2^30 - 2^26
  localparam longint TGT  = 64'd1073741824;
  localparam longint BIG  = 64'd140737488355328; // 2^47

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  longint exp_gain;
  bit     exp_locked;
  longint q_out[$], q_pwr[$], q8[$], q32[$];

  always #5 clk = ~clk;

  agc_gain_loop_if bus ();
  agc_gain_loop_if bus8 ();
  agc_gain_loop_if bus32 ();

  agc_gain_loop dut (.clk(clk), .rst(rst), .bus(bus));
  agc_gain_loop #(.GAIN_INIT(18'd8192))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  agc_gain_loop #(.GAIN_INIT(18'd32768)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  assign bus8.in_valid  = bus.in_valid;
  assign bus8.in_data   = bus.in_data;
  assign bus8.level_in  = 48'h0000_4000_0000;
  assign bus32.in_valid = bus.in_valid;
  assign bus32.in_data  = bus.in_data;
  assign bus32.level_in = 48'h0000_4000_0000;
`ifdef AGC_FREEZE_EN
  assign bus8.freeze  = 1'b0;
  assign bus32.freeze = 1'b0;
`endif

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint gain_apply(input longint d, input longint g);
    longint r;
    r = (d * g + 64'sd8192) >>> 14;
    if (r > 64'sd32767) r = 64'sd32767;
    if (r < -64'sd32768) r = -64'sd32768;
    return r;
  endfunction

  function automatic longint pwr(input longint o);
    return (o * o) >> 5;
  endfunction

  task automatic update_model(input longint level, input bit frz);
    longint step;
    step = exp_gain / 16;
    if (step < 1) step = 1;
    if (!frz) begin
      if (level > HI) begin
        exp_gain   = (exp_gain - step < 256) ? 64'd256 : exp_gain - step;
        exp_locked = 1'b0;
      end else if (level < LO) begin
        exp_gain   = (exp_gain + step > 262143) ? 64'd262143 : exp_gain + step;
        exp_locked = 1'b0;
      end else begin
        exp_locked = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic signed [15:0] d);
    longint o;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    o = gain_apply(d, exp_gain);
    q_out.push_back(o);
    q_pwr.push_back(pwr(o));
    q8.push_back(gain_apply(d, 64'd8192));
    q32.push_back(gain_apply(d, 64'd32768));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic clear_sb();
    q_out.delete(); q_pwr.delete(); q8.delete(); q32.delete();
    exp_gain   = 64'd16384;
    exp_locked = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    clear_sb();
    idle(2);
    rst = 1'b0;
  endtask

  // One full update period; the gain must move exactly 6 cycles after the 64th output
  task automatic period(input longint level, input bit frz);
    bus.level_in = level[47:0];
`ifdef AGC_FREEZE_EN
    bus.freeze = frz;
`endif
    for (int i = 0; i < 64; i++) drive(16'($urandom));
    idle(7);
    check("gain_before_adjust", bus.gain, exp_gain);
    update_model(level, frz);
    idle(1);
    check("gain_after_adjust", bus.gain, exp_gain);
    check("locked", bus.locked, exp_locked);
  endtask

  // Scoreboard monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (q_out.size() == 0) check("out_unexpected", q_out.size(), 1);
      else check("out_data", bus.out_data, q_out.pop_front());
    end
    if (bus.ema_valid === 1'b1) begin
      if (q_pwr.size() == 0) check("ema_unexpected", q_pwr.size(), 1);
      else check("ema_d", bus.ema_d, q_pwr.pop_front());
    end
    if (bus8.out_valid === 1'b1) begin
      if (q8.size() == 0) check("g8_unexpected", q8.size(), 1);
      else check("g8_out_data", bus8.out_data, q8.pop_front());
    end
    if (bus32.out_valid === 1'b1) begin
      if (q32.size() == 0) check("g32_unexpected", q32.size(), 1);
      else check("g32_out_data", bus32.out_data, q32.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.level_in = TGT[47:0];
`ifdef AGC_FREEZE_EN
    bus.freeze = 1'b0;
`endif
    clear_sb();
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_ema_valid", bus.ema_valid, 0);
    check("rst_ema_d", bus.ema_d, 0);
    check("rst_gain", bus.gain, 16384);
    check("rst_locked", bus.locked, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Unity gain latency: output two cycles after input, power one cycle later
    drive(16'sd1000);
    idle(1);
    check("lat_not_yet", bus.out_valid, 0);
    idle(1);
    check("lat_out_valid", bus.out_valid, 1);
    check("lat_out_data", bus.out_data, 1000);
    idle(1);
    check("lat_ema_valid", bus.ema_valid, 1);
    check("lat_ema_d", bus.ema_d, 31250);

    // Rounding and saturation (main at 16384, aux at 8192 and 32768)
    drive(16'sd3);
    drive(-16'sd3);
    drive(16'sd30000);
    drive(-16'sd30000);
    drive(16'sd32767);
    drive(-16'sd32768);
    idle(5);
    apply_reset();

    // Level far below target: step up until saturation
    period(0, 1'b0);
    check("first_up", exp_gain, 17408);
    period(0, 1'b0);
    check("second_up", exp_gain, 18496);
    for (int i = 0; i < 100 && exp_gain < 262143; i++) period(0, 1'b0);
    period(0, 1'b0);
    period(0, 1'b0);
    check("sat_max", bus.gain, 262143);

    // Level far above target: step down to the floor and stay there
    for (int i = 0; i < 200 && exp_gain > 256; i++) period(BIG, 1'b0);
    period(BIG, 1'b0);
    period(BIG, 1'b0);
    check("sat_min", bus.gain, 256);

    // Reset while in WAIT with samples still in flight
    bus.level_in = BIG[47:0];
    for (int i = 0; i < 67; i++) drive(16'($urandom));
    #1;
    rst = 1'b1;
    #1;
    check("wait_rst_out_valid", bus.out_valid, 0);
    check("wait_rst_out_data", bus.out_data, 0);
    check("wait_rst_ema_valid", bus.ema_valid, 0);
    check("wait_rst_ema_d", bus.ema_d, 0);
    check("wait_rst_gain", bus.gain, 16384);
    check("wait_rst_locked", bus.locked, 0);
    clear_sb();
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.level_in = 48'd0;
    for (int i = 0; i < 63; i++) drive(16'($urandom));
    idle(12);
    check("no_early_update", bus.gain, exp_gain);
    drive(16'($urandom));
    idle(12);
    update_model(0, 1'b0);
    check("update_after_64", bus.gain, exp_gain);
    apply_reset();

    // Dead-band behaviour and its exact edges
    period(TGT, 1'b0);
    period(HI + 1, 1'b0);
    check("above_window", exp_gain, 15360);
    period(HI, 1'b0);
    period(LO, 1'b0);
    period(LO - 1, 1'b0);

`ifdef AGC_FREEZE_EN
    apply_reset();
    period(0, 1'b1);
    check("freeze_hold", bus.gain, 16384);
    period(TGT, 1'b0);
    period(0, 1'b1);
    period(BIG, 1'b1);
`endif

    idle(6);
    check("sb_drain", q_out.size() + q_pwr.size() + q8.size() + q32.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
